mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port unified memory between the instruction-fetch requester and the load/store data requester.
- Sequences each access through fixed phases: arbitrate, issue, wait for memory latency, respond.
- Default policy gives the data port priority. A starvation counter guarantees fetch forward progress.
- Sits between the CPU core and the memory array, replacing the direct dual-port hookup.

Parameters:
- AW, 10: word-address width.
- DW, 32: data width.
- MEM_LAT, 1: cycles from the issue cycle until mem_rdata is valid. Legal range 1..15.
- STARVE_MAX, 4: consecutive lost arbitrations after which the fetch port is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  AW  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DW  registered fetch data.
- dm_req  in  1  data request, level; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DW  registered read data.
- mem_en  out  1  memory strobe; high only in the ISSUE state.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0, including both rdata registers and the mem_* registers. The starvation counter is cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant dm, unless starve_cnt == STARVE_MAX, in which case grant if.
  - On grant: latch the winner id, address, we (fetch is always a read) and wdata into the mem_* registers, then go to ISSUE.
- ISSUE: lasts 1 cycle. mem_en = 1 and mem_we = latched we. Next state is WAIT with lat_cnt = MEM_LAT.
- WAIT:
  - lat_cnt decrements once per cycle.
  - In the final WAIT cycle (lat_cnt == 1), mem_rdata is captured into the winner's rdata register on reads only. On writes, rdata keeps its previous value.
  - Then go to RESP.
- RESP: lasts 1 cycle. The winner's ack = 1, then return to IDLE.
- Latency: request seen in IDLE at cycle 0 gives ack at cycle MEM_LAT+2. There is always at least one IDLE cycle between consecutive accesses.
- Requester contract: the requester may drop or change req and its fields on the clock edge at which it samples ack. If req is still high in the following IDLE cycle, it is a new request.
- Starvation counter (starve_cnt):
  - Increments on each IDLE arbitration where both requests are pending and dm wins.
  - Cleared whenever if is granted.
  - Saturates at STARVE_MAX.
- Requests seen outside IDLE are ignored, not queued. The losing requester keeps its req asserted.
- Exactly one ack is issued per access. if_ack and dm_ack are never high in the same cycle.
- Reset mid-operation: state returns to IDLE on the next edge and no ack is issued. A write already issued may have committed to memory.
- mem_addr and mem_wdata hold their last latched values outside ISSUE.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined:
  - Adds output ports if_grant_cnt [15:0] and dm_grant_cnt [15:0].
  - Each counter increments by 1 on every IDLE grant to its port and wraps at 0xFFFF.
  - Both counters clear on reset.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single read: MEM_LAT=1, mem[5]=0x00001234, dm_req with dm_addr=5 at cycle 0 -> mem_en=1 with mem_addr=5 at cycle 1; dm_ack=1 with dm_rdata=0x00001234 at cycle 3; busy high for cycles 1-3.
- Write then fetch: dm write addr 7 data 0xDEADBEEF, then if_req addr 7 -> mem_we=1 during ISSUE; if_rdata=0xDEADBEEF at if_ack; dm_rdata unchanged by the write.
- Contention: if_req and dm_req both rise at cycle 0, MEM_LAT=1 -> dm_ack at cycle 3, if granted at cycle 4, if_ack at cycle 7; the two acks never overlap.
- Starvation: STARVE_MAX=4, dm_req held high continuously (re-requesting after each ack), if_req held high -> the first four grants go to dm and the fifth goes to if; starve_cnt is back to 0 after that grant.
- Reset mid-access: assert reset for 1 cycle during WAIT -> no ack, busy=0 and all outputs 0 on the next cycle; a subsequent dm read of mem[5] returns 0x00001234 normally.
- Stats (macro defined): 3 dm accesses and 2 if accesses -> dm_grant_cnt=3 and if_grant_cnt=2; after reset both read 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the arbiter and the unified
// single-port memory. The arbiter uses the master modport (it masters the
// memory and answers both requesters); the surrounding system uses slave.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // Instruction-fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  // Load/store requester
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  // Memory array side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Status
  logic          busy;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port and
// the load/store port. Every access walks IDLE -> ISSUE -> WAIT -> RESP.
// The data port wins ties unless the fetch port has lost STARVE_MAX
// arbitrations in a row.
// Optional grant statistics: define MEM_PORT_ARBITER_STATS_EN to add the
// if_grant_cnt / dm_grant_cnt output counters.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [15:0]          if_grant_cnt,
  output logic [15:0]          dm_grant_cnt
`endif
);

  localparam logic [3:0] MEM_LAT_C    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t     state_q, state_d;
  logic       grant_if, grant_dm;
  logic       win_if_q;     // 1: current access belongs to the fetch port
  logic       we_q;         // latched write flag of the current access
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;

  // Arbitration: only meaningful in IDLE; requests elsewhere are ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.if_req && (!bus.dm_req || starve_cnt == STARVE_MAX_C)) begin
        grant_if = 1'b1;
      end else if (bus.dm_req) begin
        grant_dm = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant_if || grant_dm) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (lat_cnt == 4'd1) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes and acks are pure decodes of the state.
  always_comb begin
    bus.mem_en = (state_q == ST_ISSUE);
    bus.mem_we = (state_q == ST_ISSUE) && we_q;
    bus.if_ack = (state_q == ST_RESP) &&  win_if_q;
    bus.dm_ack = (state_q == ST_RESP) && !win_if_q;
    bus.busy   = (state_q != ST_IDLE);
  end

  // Access datapath: latch the winner on grant, count latency, capture data.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_if_q      <= 1'b0;
      we_q          <= 1'b0;
      lat_cnt       <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_if) begin
            win_if_q     <= 1'b1;
            we_q         <= 1'b0;          // fetch is always a read
            bus.mem_addr <= bus.if_addr;
          end else if (grant_dm) begin
            win_if_q      <= 1'b0;
            we_q          <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
          end
        end
        ST_ISSUE: lat_cnt <= MEM_LAT_C;
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // Last WAIT cycle: memory data is valid now; writes leave rdata alone.
          if (lat_cnt == 4'd1 && !we_q) begin
            if (win_if_q) bus.if_rdata <= bus.mem_rdata;
            else          bus.dm_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts consecutive contended arbitrations lost by fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && bus.if_req && starve_cnt != STARVE_MAX_C) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  // Grant statistics: free-running, wrapping per-port grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
    end else begin
      if (grant_if) if_grant_cnt <= if_grant_cnt + 16'd1;
      if (grant_dm) dm_grant_cnt <= dm_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural single-port memory
// answers the arbiter; expected responses are queued when a request is
// driven and compared when the matching ack appears.
// Stimulus is driven and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;
  localparam int AW         = 10;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;
  localparam int ACK_BUDGET = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] if_grant_cnt;
  logic [15:0] dm_grant_cnt;
`endif

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .if_grant_cnt (if_grant_cnt),
    .dm_grant_cnt (dm_grant_cnt)
`endif
  );

  // Behavioural memory: read data appears MEM_LAT (=1) cycle after issue.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  // Scoreboard
  typedef struct {
    logic          is_if;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_dm_rdata;
  int            n_vec;
  int            n_err;

  // Predict the response of one access and queue it.
  task automatic push_exp(input logic is_if, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t e;
    e.is_if = is_if;
    if (we) begin
      ref_mem[addr] = wdata;
    end else if (is_if) begin
      exp_if_rdata = ref_mem[addr];
    end else begin
      exp_dm_rdata = ref_mem[addr];
    end
    e.data = is_if ? exp_if_rdata : exp_dm_rdata;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic is_if, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  // Wait (bounded) for either ack; cyc counts falling edges since the call.
  task automatic wait_ack(output int cyc, output logic seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < ACK_BUDGET && !seen) begin
      @(negedge clk);
      cyc++;
      if (bus.if_ack || bus.dm_ack) seen = 1'b1;
    end
  endtask

  // One complete access from an IDLE cycle; leaves the bench in the next IDLE.
  task automatic run_access(input string name, input logic is_if, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int   cyc;
    logic seen;
    exp_t e;
    push_exp(is_if, we, addr, wdata);
    drive_req(is_if, we, addr, wdata);
    wait_ack(cyc, seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: no ack within %0d cycles", name, ACK_BUDGET);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.if_ack !== e.is_if || bus.dm_ack !== !e.is_if || cyc != MEM_LAT + 2) begin
        n_err++;
        $display("FAIL %s ack: if_ack=%b dm_ack=%b at cycle %0d, required if_ack=%b at cycle %0d",
                 name, bus.if_ack, bus.dm_ack, cyc, e.is_if, MEM_LAT + 2);
      end
      n_vec++;
      if ((e.is_if ? bus.if_rdata : bus.dm_rdata) !== e.data) begin
        n_err++;
        $display("FAIL %s rdata: got %h, required %h", name,
                 e.is_if ? bus.if_rdata : bus.dm_rdata, e.data);
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.mem_en, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.busy} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: if_ack=%b if_rdata=%h dm_ack=%b dm_rdata=%h mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h busy=%b, required all 0",
               bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata, bus.busy);
    end
    reset = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    exp_t e;
    push_exp(1'b0, 1'b0, 10'd5, '0);
    drive_req(1'b0, 1'b0, 10'd5, '0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.mem_en !== (c == 1) || bus.busy !== 1'b1 || bus.dm_ack !== (c == 3) ||
          bus.if_ack !== 1'b0) begin
        n_err++;
        $display("FAIL single_read cycle %0d: mem_en=%b busy=%b dm_ack=%b if_ack=%b, required mem_en=%b busy=1 dm_ack=%b if_ack=0",
                 c, bus.mem_en, bus.busy, bus.dm_ack, bus.if_ack, c == 1, c == 3);
      end
      if (c == 1) begin
        n_vec++;
        if (bus.mem_addr !== 10'd5 || bus.mem_we !== 1'b0) begin
          n_err++;
          $display("FAIL single_read issue: mem_addr=%0d mem_we=%b, required 5 and 0",
                   bus.mem_addr, bus.mem_we);
        end
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (bus.dm_rdata !== e.data) begin
      n_err++;
      $display("FAIL single_read rdata: got %h, required %h", bus.dm_rdata, e.data);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_read idle busy: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_write_then_fetch();
    logic [DW-1:0] prev_dm;
    int            cyc;
    logic          seen;
    prev_dm = exp_dm_rdata;
    push_exp(1'b0, 1'b1, 10'd7, 32'hDEAD_BEEF);
    drive_req(1'b0, 1'b1, 10'd7, 32'hDEAD_BEEF);
    @(negedge clk);
    n_vec++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd7 ||
        bus.mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL write_issue: mem_en=%b mem_we=%b mem_addr=%0d mem_wdata=%h, required 1 1 7 deadbeef",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    wait_ack(cyc, seen);
    void'(sb.pop_front());
    n_vec++;
    if (!seen || bus.dm_ack !== 1'b1 || bus.dm_rdata !== prev_dm) begin
      n_err++;
      $display("FAIL write_ack: seen=%b dm_ack=%b dm_rdata=%h, required 1 1 %h",
               seen, bus.dm_ack, bus.dm_rdata, prev_dm);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    run_access("fetch_after_write", 1'b1, 1'b0, 10'd7, '0);
  endtask

  task automatic test_contention();
    int   dm_c = 0;
    int   if_c = 0;
    exp_t e;
    push_exp(1'b0, 1'b0, 10'd5, '0);
    push_exp(1'b1, 1'b0, 10'd7, '0);
    drive_req(1'b0, 1'b0, 10'd5, '0);
    drive_req(1'b1, 1'b0, 10'd7, '0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.if_ack && bus.dm_ack) begin
        n_vec++;
        n_err++;
        $display("FAIL contention overlap: both acks high at cycle %0d, required at most one", c);
      end else if (bus.if_ack || bus.dm_ack) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.if_ack !== e.is_if ||
            (e.is_if ? bus.if_rdata : bus.dm_rdata) !== e.data) begin
          n_err++;
          $display("FAIL contention order: if_ack=%b rdata=%h, required if_ack=%b rdata=%h",
                   bus.if_ack, e.is_if ? bus.if_rdata : bus.dm_rdata, e.is_if, e.data);
        end
        if (bus.dm_ack) begin dm_c = c; bus.dm_req = 1'b0; end
        if (bus.if_ack) begin if_c = c; bus.if_req = 1'b0; end
      end
    end
    n_vec++;
    if (dm_c != 3 || if_c != 7) begin
      n_err++;
      $display("FAIL contention timing: dm_ack at %0d if_ack at %0d, required 3 and 7", dm_c, if_c);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  task automatic test_starvation();
    int   n_dm = 0;
    int   acks = 0;
    int   c    = 0;
    exp_t e;
    for (int i = 0; i < STARVE_MAX; i++) push_exp(1'b0, 1'b0, 10'd5, '0);
    push_exp(1'b1, 1'b0, 10'd7, '0);
    drive_req(1'b0, 1'b0, 10'd5, '0);
    drive_req(1'b1, 1'b0, 10'd7, '0);
    while (acks < STARVE_MAX + 1 && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.if_ack || bus.dm_ack) begin
        acks++;
        e = sb.pop_front();
        n_vec++;
        if (bus.if_ack !== e.is_if || bus.dm_ack !== !e.is_if ||
            (e.is_if ? bus.if_rdata : bus.dm_rdata) !== e.data) begin
          n_err++;
          $display("FAIL starvation grant %0d: if_ack=%b dm_ack=%b, required if_ack=%b rdata=%h",
                   acks, bus.if_ack, bus.dm_ack, e.is_if, e.data);
        end
        if (bus.dm_ack) n_dm++;
        n_vec++;
        if (dut.starve_cnt !== 4'((bus.if_ack === 1'b1) ? 0 : n_dm)) begin
          n_err++;
          $display("FAIL starvation counter after grant %0d: got %0d, required %0d",
                   acks, dut.starve_cnt, (bus.if_ack === 1'b1) ? 0 : n_dm);
        end
        if (bus.if_ack) begin
          bus.if_req = 1'b0;
          bus.dm_req = 1'b0;
        end
      end
    end
    n_vec++;
    if (acks != STARVE_MAX + 1) begin
      n_err++;
      $display("FAIL starvation progress: %0d acks, required %0d", acks, STARVE_MAX + 1);
      sb.delete();
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    drive_req(1'b0, 1'b0, 10'd5, '0);
    repeat (2) @(negedge clk);          // now in WAIT
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.mem_en, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid outputs: busy=%b dm_ack=%b dm_rdata=%h mem_addr=%h mem_wdata=%h, required all 0",
               bus.busy, bus.dm_ack, bus.dm_rdata, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    bus.dm_req = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    repeat (5) begin
      @(negedge clk);
      if (bus.if_ack || bus.dm_ack) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL reset_mid stray ack: %0d acks, required 0", acks);
    end
    run_access("read_after_reset", 1'b0, 1'b0, 10'd5, '0);
  endtask

`ifdef MEM_PORT_ARBITER_STATS_EN
  task automatic test_stats();
    pulse_reset();
    for (int i = 0; i < 3; i++) run_access("stats_dm", 1'b0, 1'b0, 10'(5 + i), '0);
    for (int i = 0; i < 2; i++) run_access("stats_if", 1'b1, 1'b0, 10'(7 + i), '0);
    n_vec++;
    if (dm_grant_cnt !== 16'd3 || if_grant_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL stats counts: dm=%0d if=%0d, required 3 and 2", dm_grant_cnt, if_grant_cnt);
    end
    pulse_reset();
    n_vec++;
    if (dm_grant_cnt !== 16'd0 || if_grant_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stats reset: dm=%0d if=%0d, required 0 and 0", dm_grant_cnt, if_grant_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem[5]     = 32'h0000_1234;
    ref_mem[5] = 32'h0000_1234;
    mem[6]     = 32'hCAFE_0006;
    ref_mem[6] = 32'hCAFE_0006;
    rd_q         = '0;
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;

    test_reset();
    test_single_read();
    test_write_then_fetch();
    test_contention();
    test_starvation();
    test_reset_mid_access();
    run_access("back_to_back_dm", 1'b0, 1'b0, 10'd6, '0);
    run_access("back_to_back_if", 1'b1, 1'b0, 10'd5, '0);
`ifdef MEM_PORT_ARBITER_STATS_EN
    test_stats();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
